// File: rtl/rf_write_arbiter_if.sv
// Writeback bus shared between the producers and the register-file write arbiter.
//   master : producer/test side (drives requests, stall, flush; observes grants and rf port)
//   slave  : arbiter side
// Signals:
//   src_valid/src_waddr/src_wdata : per-source request, packed, source 0 in LSBs
//   src_ready                     : one-hot grant
//   stall/flush                   : register-file port unavailable / discard held entry
//   rf_we/rf_waddr/rf_wdata       : register-file write port
//   idle                          : nothing held and nothing requested
interface rf_write_arbiter_if #(
   parameter int unsigned NUM_SRC        = 3,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5
);
   logic [NUM_SRC-1:0]                src_valid;
   logic [NUM_SRC*REG_ADDR_WIDTH-1:0] src_waddr;
   logic [NUM_SRC*DATA_WIDTH-1:0]     src_wdata;
   logic [NUM_SRC-1:0]                src_ready;
   logic                              stall;
   logic                              flush;
   logic                              rf_we;
   logic [REG_ADDR_WIDTH-1:0]         rf_waddr;
   logic [DATA_WIDTH-1:0]             rf_wdata;
   logic                              idle;

   modport master (
      output src_valid, src_waddr, src_wdata, stall, flush,
      input  src_ready, rf_we, rf_waddr, rf_wdata, idle
   );

   modport slave (
      input  src_valid, src_waddr, src_wdata, stall, flush,
      output src_ready, rf_we, rf_waddr, rf_wdata, idle
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between
// NUM_SRC writeback producers, with a one-entry registered output stage.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : rf_write_arbiter_if.slave (requests, grants, stall/flush, rf port, idle)
//   perf_conflict_cnt, perf_stall_cnt : saturating counters, present only when
//               RF_WRITE_ARB_PERF_EN is defined
module rf_write_arbiter #(
   parameter int unsigned NUM_SRC        = 3,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned REG_ZERO_IDX   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   rf_write_arbiter_if.slave     bus
`ifdef RF_WRITE_ARB_PERF_EN
   ,
   output logic [31:0]           perf_conflict_cnt,
   output logic [31:0]           perf_stall_cnt
`endif
);

   localparam int unsigned PTR_W = $clog2(NUM_SRC);
   localparam int unsigned AW    = REG_ADDR_WIDTH;
   localparam int unsigned DW    = DATA_WIDTH;

   logic [PTR_W-1:0]   rr_ptr;
   logic               out_vld;
   logic [AW-1:0]      out_addr;
   logic [DW-1:0]      out_data;

   logic [NUM_SRC-1:0] grant_c;
   logic [PTR_W-1:0]   gnt_idx_c;
   logic               gnt_any_c;
   logic [PTR_W-1:0]   ptr_nxt_c;
   logic [AW-1:0]      gnt_addr_c;
   logic [DW-1:0]      gnt_data_c;
   int unsigned        cand_c;

   // Round-robin search from rr_ptr; no grant while stalled or in reset
   always_comb begin
      grant_c   = '0;
      gnt_idx_c = '0;
      gnt_any_c = 1'b0;
      cand_c    = 0;
      if (!rst && !bus.stall) begin
         for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand_c = (32'(rr_ptr) + k) % NUM_SRC;
            if (!gnt_any_c && bus.src_valid[PTR_W'(cand_c)]) begin
               gnt_any_c                = 1'b1;
               gnt_idx_c                = PTR_W'(cand_c);
               grant_c[PTR_W'(cand_c)]  = 1'b1;
            end
         end
      end
   end

   // One-hot AND-OR mux of the granted source's payload
   always_comb begin
      gnt_addr_c = '0;
      gnt_data_c = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (grant_c[i]) begin
            gnt_addr_c = gnt_addr_c | bus.src_waddr[i*AW +: AW];
            gnt_data_c = gnt_data_c | bus.src_wdata[i*DW +: DW];
         end
      end
   end

   assign ptr_nxt_c = (gnt_idx_c == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx_c + 1'b1;

   // Pointer and output stage; a grant during flush is consumed but never written
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr   <= '0;
         out_vld  <= 1'b0;
         out_addr <= '0;
         out_data <= '0;
      end else begin
         if (gnt_any_c) begin
            rr_ptr <= ptr_nxt_c;
         end
         if (!bus.stall) begin
            out_vld <= gnt_any_c && (gnt_addr_c != AW'(REG_ZERO_IDX));
            if (gnt_any_c) begin
               out_addr <= gnt_addr_c;
               out_data <= gnt_data_c;
            end
         end
         if (bus.flush) begin
            out_vld <= 1'b0;
         end
      end
   end

   assign bus.src_ready = grant_c;
   assign bus.rf_we     = out_vld && !bus.stall && !bus.flush;
   assign bus.rf_waddr  = out_addr;
   assign bus.rf_wdata  = out_data;
   assign bus.idle      = !out_vld && (bus.src_valid == '0);

`ifdef RF_WRITE_ARB_PERF_EN
   // Saturating event counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_conflict_cnt <= '0;
         perf_stall_cnt    <= '0;
      end else begin
         if (!bus.stall && ($countones(bus.src_valid) > 1) && (perf_conflict_cnt != '1)) begin
            perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
         end
         if (bus.stall && out_vld && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios followed by
// randomized producers; a reference model pushes expected writes into a queue
// that a negedge monitor pops whenever rf_we is seen.
module tb_rf_write_arbiter;

   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   bit   chk_en = 1'b0;

   rf_write_arbiter_if #(.NUM_SRC(N), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

`ifdef RF_WRITE_ARB_PERF_EN
   logic [31:0] perf_conflict_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   rf_write_arbiter #(
      .NUM_SRC(N), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .REG_ZERO_IDX(0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef RF_WRITE_ARB_PERF_EN
      ,
      .perf_conflict_cnt(perf_conflict_cnt),
      .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state (spec-level)
   int            m_ptr;
   bit            m_vld;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   int            m_conf;
   int            m_stl;
   logic [N-1:0]  exp_ready;
   bit            exp_idle;
   int            last_grant;
   wr_t           exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_vld = 0; m_addr = '0; m_data = '0;
      m_conf = 0; m_stl = 0;
      exp_q.delete();
   endtask

   task automatic model_eval(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                             input logic [N*DW-1:0] d, input bit st, input bit fl);
      int g;
      wr_t w;
      g = -1;
      exp_ready = '0;
      if (!st) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && v[idx]) g = idx;
         end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      exp_idle = !m_vld && (v == '0);
      if (!st && $countones(v) > 1) m_conf++;
      if (st && m_vld) m_stl++;
      if (m_vld && !st && !fl) begin
         w.cyc = cyc; w.addr = m_addr; w.data = m_data;
         exp_q.push_back(w);
      end
      if (g >= 0) m_ptr = (g + 1) % N;
      if (!st) begin
         m_vld = (g >= 0) && (a[g*AW +: AW] != '0);
         if (g >= 0) begin
            m_addr = a[g*AW +: AW];
            m_data = d[g*DW +: DW];
         end
      end
      if (fl) m_vld = 0;
      last_grant = g;
   endtask

   // Drive one cycle of stimulus (entered and left at posedge+1)
   task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                       input logic [N*DW-1:0] d, input bit st, input bit fl);
      bus.src_valid = v;
      bus.src_waddr = a;
      bus.src_wdata = d;
      bus.stall     = st;
      bus.flush     = fl;
      model_eval(v, a, d, st, fl);
      chk_en = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_step();
      step('0, '0, '0, 1'b0, 1'b0);
   endtask

   // Monitor: grants/idle every cycle, writes popped from the scoreboard
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         wr_t e;
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            total++; bad++;
            $display("FAIL missed_write want_cyc=%0d now=%0d addr=%0h", exp_q[0].cyc, cyc, exp_q[0].addr);
            void'(exp_q.pop_front());
         end
         chk("src_ready", 64'(bus.src_ready), 64'(exp_ready));
         chk("idle", 64'(bus.idle), 64'(exp_idle));
         if (bus.rf_we) begin
            if (exp_q.size() == 0) begin
               chk("spurious_we", 64'(bus.rf_we), 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("we_cycle", 64'(cyc), 64'(e.cyc));
               chk("rf_waddr", 64'(bus.rf_waddr), 64'(e.addr));
               chk("rf_wdata", 64'(bus.rf_wdata), 64'(e.data));
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            chk("rf_we", 64'(bus.rf_we), 64'd1);
            void'(exp_q.pop_front());
         end
      end
   end

   logic          hold [N];
   logic [AW-1:0] ha   [N];
   logic [DW-1:0] hd   [N];

   initial begin
      logic [N-1:0]    v;
      logic [N*AW-1:0] a;
      logic [N*DW-1:0] d;

      rst = 1'b1;
      bus.src_valid = 3'b111;
      bus.src_waddr = '0;
      bus.src_wdata = '0;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      model_reset();
      #12;
      chk("rst_src_ready", 64'(bus.src_ready), 64'd0);
      chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
      chk("rst_rf_waddr", 64'(bus.rf_waddr), 64'd0);
      chk("rst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
      bus.src_valid = '0;
      #1;
      chk("rst_idle", 64'(bus.idle), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single source
      step(3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 1'b0, 1'b0);
      idle_step();
      idle_step();

      // Contention, then same-address serialization
      repeat (4) step(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC3, 32'hB2, 32'hA1}, 1'b0, 1'b0);
      step(3'b011, {5'd0, 5'd4, 5'd4}, {32'h0, 32'hBBBB, 32'hAAAA}, 1'b0, 1'b0);
      step(3'b011, {5'd0, 5'd4, 5'd4}, {32'h0, 32'hBBBB, 32'hAAAA}, 1'b0, 1'b0);
      idle_step();

      // Stall hold with pending source 2
      step(3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'h77, 32'h0}, 1'b0, 1'b0);
      repeat (3) step(3'b100, {5'd12, 5'd0, 5'd0}, {32'hCC, 32'h0, 32'h0}, 1'b1, 1'b0);
      step(3'b100, {5'd12, 5'd0, 5'd0}, {32'hCC, 32'h0, 32'h0}, 1'b0, 1'b0);
      idle_step();

      // Zero register
      step(3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h1234}, 1'b0, 1'b0);
      idle_step();

      // Flush: held entry dropped, grant in flush cycle consumed
      step(3'b001, {5'd0, 5'd0, 5'd9}, {32'h0, 32'h0, 32'h99}, 1'b0, 1'b0);
      step(3'b010, {5'd0, 5'd10, 5'd0}, {32'h0, 32'hAA, 32'h0}, 1'b0, 1'b1);
      idle_step();
      idle_step();

      // Async reset with a held entry; rr pointer left at 1
      step(3'b001, {5'd0, 5'd0, 5'd9}, {32'h0, 32'h0, 32'h5A5A}, 1'b0, 1'b0);
      chk_en = 1'b0;
      bus.src_valid = '0;
      chk("pre_rst_we", 64'(bus.rf_we), 64'(m_vld));
      #2;
      rst = 1'b1;
      #1;
      chk("arst_rf_we", 64'(bus.rf_we), 64'd0);
      chk("arst_src_ready", 64'(bus.src_ready), 64'd0);
      chk("arst_rf_waddr", 64'(bus.rf_waddr), 64'd0);
      chk("arst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
      chk("arst_idle", 64'(bus.idle), 64'd1);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 1'b0, 1'b0);
      chk("post_rst_grant", 64'(last_grant), 64'd0);
      idle_step();

      // Randomized producers holding requests until granted
      for (int i = 0; i < N; i++) begin
         hold[i] = 1'b0; ha[i] = '0; hd[i] = '0;
      end
      repeat (2000) begin
         for (int i = 0; i < N; i++) begin
            if (!hold[i] && $urandom_range(0, 99) < 60) begin
               hold[i] = 1'b1;
               ha[i] = AW'($urandom_range(0, 31));
               hd[i] = $urandom;
            end
            v[i] = hold[i];
            a[i*AW +: AW] = ha[i];
            d[i*DW +: DW] = hd[i];
         end
         step(v, a, d, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8);
         if (last_grant >= 0) hold[last_grant] = 1'b0;
      end

      repeat (3) idle_step();
      chk("drain", 64'(exp_q.size()), 64'd0);
`ifdef RF_WRITE_ARB_PERF_EN
      chk("perf_conflict", 64'(perf_conflict_cnt), 64'(m_conf));
      chk("perf_stall", 64'(perf_stall_cnt), 64'(m_stl));
`endif
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between NUM_SRC writeback producers: ALU writeback, load return and SFU/long-latency return.
- Per-source valid/ready handshake, round-robin grant, one registered output stage that drives rf_we/rf_waddr/rf_wdata.
- Sits between the writeback producers and the register file.
- Provides an idle indication for thread-completion logic.

Parameters:
- NUM_SRC, 3, number of writeback requesters (2..8)
- DATA_WIDTH, 32, write data width
- REG_ADDR_WIDTH, 5, register address width
- REG_ZERO_IDX, 0, hardwired-zero register index; writes to it are dropped

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- src_valid  input  NUM_SRC  request from source i
- src_waddr  input  NUM_SRC*REG_ADDR_WIDTH  destination register per source, packed, source 0 in LSBs
- src_wdata  input  NUM_SRC*DATA_WIDTH  write data per source, packed
- src_ready  output  NUM_SRC  one-hot grant; a transfer occurs when src_valid[i] && src_ready[i]
- stall  input  1  register-file port unavailable this cycle
- flush  input  1  discard the registered output entry
- rf_we  output  1  register-file write enable
- rf_waddr  output  REG_ADDR_WIDTH  write address
- rf_wdata  output  DATA_WIDTH  write data
- idle  output  1  no pending or requested writes

Behaviour:
- Reset (rst high, asynchronous):
  - out_vld=0, out_addr=0, out_data=0, rr_ptr=0.
  - Hence rf_we=0, rf_waddr=0, rf_wdata=0, src_ready=0, idle=1 while in reset.
  - Reset mid-transfer drops the held entry; no write is issued.
- Grant (combinational from registered state):
  - When stall=0, src_ready is the one-hot of the first i with src_valid[i]=1, searching from rr_ptr upward with wrap modulo NUM_SRC.
  - When stall=1, src_ready=0.
  - src_ready never asserts without a matching src_valid.
- Pointer:
  - On a transfer from source g, rr_ptr <= (g+1) mod NUM_SRC.
  - With no transfer, rr_ptr holds.
- Output register (one-entry):
  - stall=0: out_vld <= any transfer && granted addr != REG_ZERO_IDX; out_addr/out_data load the granted source's addr/data. With no transfer, out_vld <= 0 and addr/data hold.
  - stall=1: the register holds all fields.
  - flush=1 (any stall value): out_vld <= 0. A grant made in the same cycle is still consumed: src_ready stays high and its data is discarded, because the producer was flushed upstream too.
- Outputs:
  - rf_we = out_vld && !stall && !flush.
  - rf_waddr = out_addr; rf_wdata = out_data.
  - Latency from transfer to rf_we is exactly 1 cycle absent stall.
- Zero register:
  - A request to REG_ZERO_IDX is accepted (handshake completes and the pointer advances) but never produces rf_we.
- Throughput: one write per cycle sustained. A held entry writes on the first stall=0 cycle, and a new grant loads in that same cycle.
- Same-address requests in one cycle are serialized in round-robin order. The last-written value is the later grant's data.
- idle = !out_vld && (src_valid == 0).
- Fairness: any continuously valid source is granted within NUM_SRC non-stall cycles.

Optional Feature:
- Macro RF_WRITE_ARB_PERF_EN.
- When defined, adds two outputs:
  - perf_conflict_cnt (32 bit): increments each non-stall cycle with more than one src_valid bit set.
  - perf_stall_cnt (32 bit): increments each cycle with stall && out_vld.
- Both counters saturate at all-ones and reset to 0 on rst.
- When not defined, the ports and logic are absent; the arbiter's behaviour is identical otherwise.

Test Plan:
- Single source: src_valid=3'b001, waddr=5, wdata=0xDEADBEEF, one cycle -> src_ready=3'b001 the same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; then idle=1.
- Contention: all three valid continuously from rr_ptr=0 -> grants 001,010,100,001 on consecutive cycles; rf_we high 4 consecutive cycles with matching data.
- Stall hold: transfer from source 1 (waddr=7), then stall=1 for 3 cycles -> rf_we=0 and src_ready=0 during the stall; rf_we=1 with waddr=7 on the first stall=0 cycle, and a pending source 2 grant loads in that same cycle.
- Zero register: source 0 waddr=0, wdata=0x1234 -> src_ready=1, rr_ptr advances to 1, rf_we stays 0, idle=1 the next cycle.
- Flush: transfer waddr=9, then flush=1 the next cycle -> rf_we=0 and the entry is dropped; a grant in the flush cycle is consumed without a write.
- Async reset: assert rst mid-stream with out_vld=1 -> rf_we, src_ready and all outputs drop to 0 before the next clock edge; after release, the first grant starts from source 0.
